// File: rtl/badge_cmd_ctrl.sv
// badge_cmd_ctrl: UART command controller for the badge.
//   Decodes 3-byte frames (CMD, ARG, CMD) from the RX byte stream. It keeps a
//   per-channel status register and a global PWM duty, answers status queries
//   over a TX valid/ready handshake, and drives dimmed per-channel LEDs.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   rx_valid, rx_data     one-cycle received-byte strobe and byte
//   tx_ready              UART TX can take a byte
//   tx_valid, tx_data     response byte stream (held until accepted)
//   status                channel status, 1 = alive
//   led_out               registered ~status gated by PWM
//   frame_ok, frame_err   one-cycle result pulses
module badge_cmd_ctrl #(
    parameter int NUM_CH         = 8,
    parameter int ARG_BASE       = 65,
    parameter int ARG_RESET      = 96,
    parameter int CMD_CLEAR      = 65,
    parameter int CMD_DUTY       = 66,
    parameter int CMD_QUERY      = 81,
    parameter int PWM_BITS       = 4,
    parameter int PWM_DIV        = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic [NUM_CH-1:0] status,
    output logic [NUM_CH-1:0] led_out,
    output logic              frame_ok,
    output logic              frame_err
);

    localparam int NB   = (NUM_CH + 7) / 8;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PS_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RW   = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [7:0] C_CLR = 8'(CMD_CLEAR);
    localparam logic [7:0] C_DTY = 8'(CMD_DUTY);
    localparam logic [7:0] C_QRY = 8'(CMD_QUERY);
    localparam logic [7:0] A_RST = 8'(ARG_RESET);
    localparam logic [7:0] A_BAS = 8'(ARG_BASE);

    typedef enum logic [1:0] {IDLE, GOT_CMD, GOT_ARG, RESP} state_t;

    state_t                state, state_nx;
    logic [7:0]            cmd_q, arg_q;
    logic [PWM_BITS-1:0]   duty;
    logic [TO_W-1:0]       to_cnt;
    logic [NB*8-1:0]       resp_buf;
    logic [RW-1:0]         rem;
    logic [PS_W-1:0]       psc;
    logic [PWM_BITS-1:0]   pwm_cnt;

    logic                  latch_cmd, latch_arg, ok_nx, err_nx;
    logic                  exec_clr, exec_set, exec_duty, exec_qry;
    logic                  to_hit, to_run, tx_fire, in_range, pwm_on;
    logic [CH_W-1:0]       arg_off;
    logic [NUM_CH-1:0]     clr_bit;

    assign in_range = ({1'b0, arg_q} >= 9'(ARG_BASE)) &&
                      ({1'b0, arg_q} <  9'(ARG_BASE + NUM_CH));
    assign arg_off  = CH_W'(arg_q - A_BAS);
    assign clr_bit  = NUM_CH'(1) << arg_off;
    assign to_hit   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    // Count only idle cycles inside a frame; any accepted byte restarts it.
    assign to_run   = (state == GOT_CMD || state == GOT_ARG) && !rx_valid && !to_hit;
    assign tx_fire  = (state == RESP) && tx_valid && tx_ready;
    assign tx_data  = resp_buf[7:0];
    assign pwm_on   = (pwm_cnt < duty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        latch_cmd = 1'b0;
        latch_arg = 1'b0;
        ok_nx     = 1'b0;
        err_nx    = 1'b0;
        exec_clr  = 1'b0;
        exec_set  = 1'b0;
        exec_duty = 1'b0;
        exec_qry  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && (rx_data == C_CLR || rx_data == C_DTY || rx_data == C_QRY)) begin
                    latch_cmd = 1'b1;
                    state_nx  = GOT_CMD;
                end
            end
            GOT_CMD: begin
                if (rx_valid) begin
                    latch_arg = 1'b1;
                    state_nx  = GOT_ARG;
                end else if (to_hit) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            GOT_ARG: begin
                if (rx_valid) begin
                    state_nx = IDLE;
                    if (rx_data != cmd_q) begin
                        err_nx = 1'b1;
                    end else if (cmd_q == C_CLR) begin
                        if (in_range) begin
                            exec_clr = 1'b1;
                            ok_nx    = 1'b1;
                        end else if (arg_q == A_RST) begin
                            exec_set = 1'b1;
                            ok_nx    = 1'b1;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end else if (cmd_q == C_DTY) begin
                        exec_duty = 1'b1;
                        ok_nx     = 1'b1;
                    end else if (cmd_q == C_QRY) begin
                        exec_qry = 1'b1;
                        ok_nx    = 1'b1;
                        state_nx = RESP;
                    end else begin
                        err_nx = 1'b1;
                    end
                end else if (to_hit) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            RESP: begin
                if (tx_fire && rem == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q     <= '0;
            arg_q     <= '0;
            status    <= '1;
            duty      <= '1;
            to_cnt    <= '0;
            resp_buf  <= '0;
            rem       <= '0;
            tx_valid  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= ok_nx;
            frame_err <= err_nx;
            to_cnt    <= to_run ? to_cnt + 1'b1 : '0;
            if (latch_cmd) cmd_q <= rx_data;
            if (latch_arg) arg_q <= rx_data;
            if (exec_clr)  status <= status & ~clr_bit;
            if (exec_set)  status <= '1;
            if (exec_duty) duty <= arg_q[PWM_BITS-1:0];
            if (exec_qry) begin
                // Snapshot, zero-extended so unused high bits go out as 0.
                resp_buf <= (NB*8)'(status);
                rem      <= RW'(NB - 1);
                tx_valid <= 1'b1;
            end else if (tx_fire) begin
                resp_buf <= resp_buf >> 8;
                if (rem == '0) tx_valid <= 1'b0;
                else           rem <= rem - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psc     <= '0;
            pwm_cnt <= '0;
            led_out <= '0;
        end else begin
            if (psc == PS_W'(PWM_DIV - 1)) begin
                psc     <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                psc <= psc + 1'b1;
            end
            led_out <= ~status & {NUM_CH{pwm_on}};
        end
    end

endmodule

// File: doc/badge_cmd_ctrl.md
Name: badge_cmd_ctrl

Overview:
Parametrised UART command controller for the badge. Consumes received bytes, decodes 3-byte frames (CMD, ARG, CMD-terminator), maintains an NUM_CH-wide channel status register and a global PWM duty, and drives dimmed per-channel LED outputs. Adds two things: a status query that returns the register over a TX valid/ready handshake, and an inter-byte timeout that resynchronises the decoder. It sits between the UART core (RX byte stream in, TX byte stream out) and the LED mux.

Parameters:
NUM_CH, 8, number of status channels (1..32)
ARG_BASE, 65 ("A"), ARG value that selects channel 0
ARG_RESET, 96 ("`"), ARG value that sets all status bits
CMD_CLEAR, 65 ("A"), clear-channel / reset-all command
CMD_DUTY, 66 ("B"), set PWM duty; ARG[PWM_BITS-1:0] is the duty
CMD_QUERY, 81 ("Q"), return status bytes on TX; ARG is ignored
PWM_BITS, 4, PWM counter and duty width
PWM_DIV, 16, clk cycles per PWM counter step (>=1)
TIMEOUT_CYCLES, 1_000_000, maximum idle cycles between bytes of one frame

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
tx_ready  in  1  UART TX can accept a byte
tx_valid  out  1  tx_data is valid
tx_data  out  8  response byte
status  out  NUM_CH  channel status (1 = alive)
led_out  out  NUM_CH  PWM-gated ~status
frame_ok  out  1  one-cycle pulse: a frame executed
frame_err  out  1  one-cycle pulse: a frame was rejected or timed out

Behaviour:
- Reset (async assert, sync deassert is the integrator's job):
  - status = all ones
  - duty = all ones
  - FSM = IDLE
  - tx_valid = 0, tx_data = 0
  - frame_ok = 0, frame_err = 0
  - PWM counter and prescaler = 0
  - timeout counter = 0
- A reset mid-frame or mid-response aborts it. No partial effects are kept.
- FSM states: IDLE, GOT_CMD, GOT_ARG, RESP.
- IDLE:
  - rx byte equal to CMD_CLEAR, CMD_DUTY or CMD_QUERY: latch it as cmd, go to GOT_CMD, clear the timeout counter.
  - Any other byte: dropped, no error.
- GOT_CMD: an rx byte is latched as arg, go to GOT_ARG, clear the timeout counter.
- GOT_ARG: the next rx byte is the terminator.
  - Terminator != cmd: frame_err, go to IDLE.
  - Terminator == cmd: execute at this edge. Register effects are visible the next cycle. frame_ok or frame_err is high the next cycle for exactly one cycle.
- CLEAR execution:
  - ARG_BASE <= arg < ARG_BASE+NUM_CH: status[arg-ARG_BASE] <= 0. Clearing an already-cleared bit is still frame_ok.
  - arg == ARG_RESET: status <= all ones.
  - Any other arg: frame_err, no change.
- DUTY execution: duty <= arg[PWM_BITS-1:0]; always frame_ok.
- QUERY execution:
  - frame_ok, go to RESP.
  - Load NB = ceil(NUM_CH/8) bytes, LSB byte first, taken from status sampled at execution.
  - Unused high bits of the last byte are 0.
- RESP:
  - tx_valid = 1 from the cycle after execution.
  - tx_data stays stable until tx_valid && tx_ready.
  - Each handshake advances to the next byte. After the handshake on the last byte: tx_valid = 0 next cycle, go to IDLE.
  - rx bytes arriving in RESP are dropped. The timeout does not run in RESP.
- Timeout: in GOT_CMD or GOT_ARG, when the counter reaches TIMEOUT_CYCLES with no rx_valid: frame_err, go to IDLE.
- If rx_valid arrives in the same cycle as the timeout, the byte wins: it is processed and there is no timeout.
- PWM:
  - Prescaler counts 0..PWM_DIV-1. At the wrap, pwm_cnt increments modulo 2^PWM_BITS.
  - pwm_on = (pwm_cnt < duty): duty 0 = always off; all ones = on for (2^PWM_BITS-1) of 2^PWM_BITS steps.
  - led_out[i] = ~status[i] & pwm_on, registered (one cycle latency).
- A duty change takes effect at the next comparison; the counter is not reset.

Test Plan:
- Reset: assert reset_n=0 mid-QUERY response -> tx_valid=0, status=8'hFF, FSM back in IDLE; after release, "A","C","A" -> status=8'hFB, frame_ok pulses once.
- Bounds, NUM_CH=8: "A","I","A" (73 = ARG_BASE+8) -> frame_err, status unchanged; "A","H","A" -> status[7]=0; "A","`","A" -> status=8'hFF.
- Bad terminator and timeout: "A","B","B" -> frame_err, no change. "B" then silence for TIMEOUT_CYCLES (set to 100) -> frame_err at cycle 100, IDLE; byte at exactly cycle 100 is accepted instead.
- Query, NUM_CH=12, status=12'hFFE, tx_ready low for 5 cycles: "Q","x","Q" -> tx_data=8'hFE held stable while tx_ready is low, then 8'h0F; then tx_valid falls; rx bytes sent during RESP are ignored.
- PWM, PWM_BITS=4, PWM_DIV=1, status=8'hFE: "B",8'h04,"B" -> led_out[0] high 4 of every 16 cycles, other bits 0; duty 0 -> led_out=0.
- Noise: random non-command bytes in IDLE -> no pulses, no state change.
